// File: rtl/npn_canon_seq.sv
// Sequential NPN canonicaliser for 4-input functions: one permutation per cycle, 32 (m,o) each.
// Optional macro NPN_CANON_XFORM_EN adds the winning transform outputs (out_perm/out_neg/out_onot).
module npn_canon_seq #(
    parameter int unsigned TT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TT_W-1:0] in_tt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TT_W-1:0] out_tt
`ifdef NPN_CANON_XFORM_EN
    ,
    output logic [4:0]      out_perm,
    output logic [3:0]      out_neg,
    output logic            out_onot
`endif
);

    if (TT_W != 16) begin : g_tt_w_check
        $error("npn_canon_seq: TT_W must be 16");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      perm_idx_q;
    logic [TT_W-1:0] f_q;
    logic [TT_W-1:0] best_q;
    logic [TT_W-1:0] s1_tt_q;
    logic            s1_valid_q;
    logic            out_valid_q;
    logic            accept;
    logic [7:0]      perm_map;
    logic [TT_W-1:0] cand;
    logic [TT_W-1:0] cand_min;
`ifdef NPN_CANON_XFORM_EN
    logic [3:0]      cand_neg;
    logic            cand_onot;
    logic [4:0]      s1_perm_q;
    logic [3:0]      s1_neg_q;
    logic            s1_onot_q;
    logic [4:0]      best_perm_q;
    logic [3:0]      best_neg_q;
    logic            best_onot_q;
`endif

    // Packs (p0,p1,p2,p3) with p0 in the low bits.
    function automatic logic [7:0] pk(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d);
        return {d, c, b, a};
    endfunction

    // Lexicographic order of (p0,p1,p2,p3).
    function automatic logic [7:0] perm_lut(input logic [4:0] idx);
        logic [7:0] p;
        case (idx)
            5'd0:    p = pk(2'd0, 2'd1, 2'd2, 2'd3);
            5'd1:    p = pk(2'd0, 2'd1, 2'd3, 2'd2);
            5'd2:    p = pk(2'd0, 2'd2, 2'd1, 2'd3);
            5'd3:    p = pk(2'd0, 2'd2, 2'd3, 2'd1);
            5'd4:    p = pk(2'd0, 2'd3, 2'd1, 2'd2);
            5'd5:    p = pk(2'd0, 2'd3, 2'd2, 2'd1);
            5'd6:    p = pk(2'd1, 2'd0, 2'd2, 2'd3);
            5'd7:    p = pk(2'd1, 2'd0, 2'd3, 2'd2);
            5'd8:    p = pk(2'd1, 2'd2, 2'd0, 2'd3);
            5'd9:    p = pk(2'd1, 2'd2, 2'd3, 2'd0);
            5'd10:   p = pk(2'd1, 2'd3, 2'd0, 2'd2);
            5'd11:   p = pk(2'd1, 2'd3, 2'd2, 2'd0);
            5'd12:   p = pk(2'd2, 2'd0, 2'd1, 2'd3);
            5'd13:   p = pk(2'd2, 2'd0, 2'd3, 2'd1);
            5'd14:   p = pk(2'd2, 2'd1, 2'd0, 2'd3);
            5'd15:   p = pk(2'd2, 2'd1, 2'd3, 2'd0);
            5'd16:   p = pk(2'd2, 2'd3, 2'd0, 2'd1);
            5'd17:   p = pk(2'd2, 2'd3, 2'd1, 2'd0);
            5'd18:   p = pk(2'd3, 2'd0, 2'd1, 2'd2);
            5'd19:   p = pk(2'd3, 2'd0, 2'd2, 2'd1);
            5'd20:   p = pk(2'd3, 2'd1, 2'd0, 2'd2);
            5'd21:   p = pk(2'd3, 2'd1, 2'd2, 2'd0);
            5'd22:   p = pk(2'd3, 2'd2, 2'd0, 2'd1);
            5'd23:   p = pk(2'd3, 2'd2, 2'd1, 2'd0);
            default: p = pk(2'd0, 2'd1, 2'd2, 2'd3);
        endcase
        return p;
    endfunction

    // g[i] = o ^ f[j], where input k of g drives bit p[k] of j (after negation by m[k]).
    function automatic logic [15:0] xform(input logic [15:0] f, input logic [7:0] p,
                                          input logic [3:0] m, input logic o);
        logic [15:0] g;
        logic [3:0]  iv;
        logic [3:0]  j;
        logic [1:0]  pos;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            j  = '0;
            for (int k = 0; k < 4; k++) begin
                pos    = p[2*k +: 2];
                j[pos] = iv[k] ^ m[k];
            end
            g[i] = o ^ f[j];
        end
        return g;
    endfunction

    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_tt    = best_q;
`ifdef NPN_CANON_XFORM_EN
    assign out_perm  = best_perm_q;
    assign out_neg   = best_neg_q;
    assign out_onot  = best_onot_q;
`endif

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun:  if (perm_idx_q == 5'd23) state_d = StDone;
            StDone: if (out_valid_q && out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Minimum over the 32 (m,o) of the current permutation; strict compare keeps the first hit.
    always_comb begin
        perm_map  = perm_lut(perm_idx_q);
        cand      = '0;
        cand_min  = xform(f_q, perm_map, 4'd0, 1'b0);
`ifdef NPN_CANON_XFORM_EN
        cand_neg  = 4'd0;
        cand_onot = 1'b0;
`endif
        for (int m = 0; m < 16; m++) begin
            for (int o = 0; o < 2; o++) begin
                cand = xform(f_q, perm_map, 4'(m), 1'(o));
                if (cand < cand_min) begin
                    cand_min  = cand;
`ifdef NPN_CANON_XFORM_EN
                    cand_neg  = 4'(m);
                    cand_onot = 1'(o);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            perm_idx_q  <= 5'd0;
            f_q         <= '0;
            best_q      <= '0;
            s1_tt_q     <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef NPN_CANON_XFORM_EN
            s1_perm_q   <= 5'd0;
            s1_neg_q    <= 4'd0;
            s1_onot_q   <= 1'b0;
            best_perm_q <= 5'd0;
            best_neg_q  <= 4'd0;
            best_onot_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            // Rises one cycle into DONE, once the last per-permutation minimum has merged.
            out_valid_q <= (state_q == StDone) && (state_d == StDone);
            s1_valid_q  <= (state_q == StRun);
            if (state_q == StRun) begin
                s1_tt_q    <= cand_min;
                perm_idx_q <= perm_idx_q + 5'd1;
`ifdef NPN_CANON_XFORM_EN
                s1_perm_q  <= perm_idx_q;
                s1_neg_q   <= cand_neg;
                s1_onot_q  <= cand_onot;
`endif
            end
            if (accept) begin
                f_q        <= in_tt;
                best_q     <= '1;
                perm_idx_q <= 5'd0;
            end else if (s1_valid_q && (s1_tt_q < best_q)) begin
                best_q      <= s1_tt_q;
`ifdef NPN_CANON_XFORM_EN
                best_perm_q <= s1_perm_q;
                best_neg_q  <= s1_neg_q;
                best_onot_q <= s1_onot_q;
`endif
            end
        end
    end

endmodule
